// File: rtl/handshake_constant_burst_if.sv
// Handshake bundle for handshake_constant_burst: control token in, constant bursts out.
// master = environment (upstream producer + downstream consumer), slave = the block.
interface handshake_constant_burst_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
  logic                  outs_last;
  logic [CNT_WIDTH-1:0]  emitted;

  modport master (
    output ctrl_valid, outs_ready,
    input  ctrl_ready, outs, outs_valid, outs_last, emitted
  );

  modport slave (
    input  ctrl_valid, outs_ready,
    output ctrl_ready, outs, outs_valid, outs_last, emitted
  );
endinterface

// File: rtl/handshake_constant_burst.sv
// Registered constant source: each accepted control token yields REPEAT copies of VALUE
// on a valid/ready channel, with a wrapping count of all copies transferred.
module handshake_constant_burst #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  VALUE      = '0,
  parameter int unsigned            REPEAT     = 1,
  parameter int unsigned            CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  handshake_constant_burst_if.slave io_hs
);

  localparam int unsigned CW = $clog2(REPEAT + 1);

  generate
    if (REPEAT < 1) begin : g_bad_repeat
      $error("handshake_constant_burst: REPEAT must be >= 1");
    end
  endgenerate

  // r_cnt = copies still owed, including the one currently presented
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_emitted;
  logic [CNT_WIDTH-1:0] w_emitted_nxt;
  logic                 w_ctrl_ready;
  logic                 w_fire_in;
  logic                 w_fire_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_emitted <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_emitted <= w_emitted_nxt;
    end
  end

  // New token is taken in the same cycle the last copy drains (no bubble at REPEAT=1)
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_emitted_nxt = r_emitted;
    w_ctrl_ready  = !rst && ((r_cnt == '0) || ((r_cnt == CW'(1)) && io_hs.outs_ready));
    w_fire_in     = io_hs.ctrl_valid && w_ctrl_ready;
    w_fire_out    = (r_cnt != '0) && io_hs.outs_ready;
    if (w_fire_in) begin
      w_cnt_nxt = CW'(REPEAT);
    end else if (w_fire_out) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
    if (w_fire_out) begin
      w_emitted_nxt = r_emitted + CNT_WIDTH'(1);
    end
  end

  assign io_hs.outs       = VALUE;
  assign io_hs.outs_valid = (r_cnt != '0);
  assign io_hs.outs_last  = (r_cnt == CW'(1));
  assign io_hs.ctrl_ready = w_ctrl_ready;
  assign io_hs.emitted    = r_emitted;

endmodule
